spi_slave_frame_ctrl: RTL and testbench

Sequencing controller for the FPGA-slave SPI port. It oversamples the master's SCK, CS and MOSI on the local clock and frames transfers into fixed 16-bit words. Each frame shifts one word out on MISO and assembles one received word. It sits between the external SPI pins and the slave's register/datapath logic, and exchanges words with it through a valid/ready transmit port and a pulse-qualified receive port.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_edge_sync.sv | 44 ++++
 rtl/spi_slave_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_frame_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave frame controller.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } spi_state_e;

  localparam int SPI_WIDTH        = 16;
  localparam int SPI_SYNC_DEFAULT = 2;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, followed by registered
// rise/fall strobes.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_frame_ctrl.sv
// SPI mode-0 slave framer: oversamples SCK/CS/MOSI on SLK, shifts one WIDTH-bit
// word out on MISO and assembles one received word per CS window.
module spi_slave_frame_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic             SLK,
  input  logic             rst,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  output logic             MISO,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             underrun,
  output logic             abort
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic mosi_s;

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  spi_state_e             state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       shift_tx_q, shift_tx_d;
  logic [WIDTH-1:0]       shift_rx_q, shift_rx_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;
  logic                   abort_q, abort_d;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (SLK),
    .rst  (rst),
    .din  (SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (SLK),
    .rst  (rst),
    .din  (CS),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end

  always_ff @(posedge SLK) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
    end
  end

  // MISO is the MSB of shift_tx, so clearing or loading shift_tx drives the pin.
  // The tx word is taken on the IDLE->LOAD edge so tx_ready is seen during LOAD.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = 1'b0;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    abort_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d = LOAD;
          if (tx_valid) begin
            shift_tx_d = tx_data;
            tx_ready_d = 1'b1;
          end else begin
            shift_tx_d = '0;
            underrun_d = 1'b1;
          end
        end else if (cs_fall) begin
          shift_tx_d = '0;
        end
      end
      LOAD: begin
        if (cs_fall) begin
          abort_d    = 1'b1;
          shift_tx_d = '0;
          state_d    = IDLE;
        end else begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_fall) begin
          abort_d    = 1'b1;
          shift_tx_d = '0;
          state_d    = IDLE;
        end else begin
          if (sck_rise) begin
            shift_rx_d = {shift_rx_q[WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = DONE;
            end
          end
          if (sck_fall) begin
            shift_tx_d = {shift_tx_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        rx_data_d  = shift_rx_q;
        rx_valid_d = 1'b1;
        state_d    = IDLE;
        if (cs_fall) begin
          shift_tx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge SLK) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign MISO     = shift_tx_q[WIDTH-1];
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Directed bench for spi_slave_frame_ctrl: bit-banged mode-0 master driven
// at SLK/6 per SCK phase, with hand-computed expected words and pulse counts.
module tb_spi_slave_frame_ctrl;

  logic        SLK = 1'b0;
  logic        rst, SCK, CS, MOSI, MISO;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, busy, underrun, abort;

  int checks = 0;
  int passes = 0;
  int n_txr = 0, n_rxv = 0, n_und = 0, n_abt = 0;

  spi_slave_frame_ctrl #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .SLK      (SLK),
    .rst      (rst),
    .SCK      (SCK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .underrun (underrun),
    .abort    (abort)
  );

  always #5 SLK = ~SLK;

  always @(negedge SLK) begin
    if (tx_ready) n_txr++;
    if (rx_valid) n_rxv++;
    if (underrun) n_und++;
    if (abort)    n_abt++;
  end

  // One CS window: nrise SCK pulses, MISO captured just before each rise.
  // start_lat: negedges from CS rise until tx_ready/underrun; rxv_lat: negedges
  // from the 16th SCK rise until rx_valid.
  task automatic spi_xfer(input logic [15:0] mosi_w, input int nrise, output logic [15:0] miso_w,
                          output int start_lat, output int rxv_lat, output logic busy_mid);
    miso_w = '0; start_lat = -1; rxv_lat = -1; busy_mid = 1'b0;
    @(negedge SLK);
    CS = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge SLK);
      if (start_lat < 0 && (tx_ready || underrun)) start_lat = c;
    end
    for (int i = 0; i < nrise; i++) begin
      MOSI = (i < 16) ? mosi_w[15-i] : 1'b0;
      repeat (6) @(negedge SLK);
      if (i < 16) miso_w[15-i] = MISO;
      if (i == 0) busy_mid = busy;
      SCK = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge SLK);
        if (i == 15 && rxv_lat < 0 && rx_valid) rxv_lat = c;
      end
      SCK = 1'b0;
    end
    repeat (6) @(negedge SLK);
    CS = 1'b0;
    repeat (10) @(negedge SLK);
  endtask

  task automatic test_reset();
    rst = 1'b1; SCK = 1'b0; CS = 1'b0; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge SLK);
    rst = 1'b0;
    @(negedge SLK);
    checks++; if (MISO !== 1'b0) $display("FAIL rst_miso: got %b want 0", MISO); else passes++;
    checks++; if (tx_ready !== 1'b0) $display("FAIL rst_tx_ready: got %b want 0", tx_ready); else passes++;
    checks++; if (rx_data !== 16'h0000) $display("FAIL rst_rx_data: got %h want 0000", rx_data); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", rx_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
    checks++; if (underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", underrun); else passes++;
    checks++; if (abort !== 1'b0) $display("FAIL rst_abort: got %b want 0", abort); else passes++;
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      SCK = 1'b1; repeat (6) @(negedge SLK);
      SCK = 1'b0; repeat (6) @(negedge SLK);
    end
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
    checks++; if (n_txr + n_rxv + n_und + n_abt !== 0)
      $display("FAIL idle_pulses: got %0d want 0", n_txr + n_rxv + n_und + n_abt); else passes++;
    checks++; if (rx_data !== 16'h0000) $display("FAIL idle_rx_data: got %h want 0000", rx_data); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL idle_miso: got %b want 0", MISO); else passes++;
  endtask

  task automatic test_nominal();
    logic [15:0] mw; int sl, rl; logic bm; int t0, r0, u0;
    t0 = n_txr; r0 = n_rxv; u0 = n_und;
    tx_data = 16'hA5C3; tx_valid = 1'b1;
    spi_xfer(16'h3C5A, 16, mw, sl, rl, bm);
    tx_valid = 1'b0;
    checks++; if (mw !== 16'hA5C3) $display("FAIL nom_miso_stream: got %h want a5c3", mw); else passes++;
    checks++; if (rx_data !== 16'h3C5A) $display("FAIL nom_rx_data: got %h want 3c5a", rx_data); else passes++;
    checks++; if (n_rxv - r0 !== 1) $display("FAIL nom_rx_valid_count: got %0d want 1", n_rxv - r0); else passes++;
    checks++; if (n_txr - t0 !== 1) $display("FAIL nom_tx_ready_count: got %0d want 1", n_txr - t0); else passes++;
    checks++; if (n_und - u0 !== 0) $display("FAIL nom_underrun_count: got %0d want 0", n_und - u0); else passes++;
    checks++; if (sl !== 4) $display("FAIL nom_tx_ready_latency: got %0d want 4", sl); else passes++;
    checks++; if (rl !== 5) $display("FAIL nom_rx_valid_latency: got %0d want 5", rl); else passes++;
    checks++; if (bm !== 1'b1) $display("FAIL nom_busy_mid: got %b want 1", bm); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL nom_busy_after: got %b want 0", busy); else passes++;
  endtask

  task automatic test_underrun();
    logic [15:0] mw; int sl, rl; logic bm; int t0, u0;
    t0 = n_txr; u0 = n_und;
    tx_data = 16'h1357; tx_valid = 1'b0;
    spi_xfer(16'hFFFF, 16, mw, sl, rl, bm);
    checks++; if (n_und - u0 !== 1) $display("FAIL und_count: got %0d want 1", n_und - u0); else passes++;
    checks++; if (n_txr - t0 !== 0) $display("FAIL und_tx_ready_count: got %0d want 0", n_txr - t0); else passes++;
    checks++; if (mw !== 16'h0000) $display("FAIL und_miso_stream: got %h want 0000", mw); else passes++;
    checks++; if (rx_data !== 16'hFFFF) $display("FAIL und_rx_data: got %h want ffff", rx_data); else passes++;
    checks++; if (sl !== 4) $display("FAIL und_latency: got %0d want 4", sl); else passes++;
  endtask

  task automatic test_abort();
    logic [15:0] mw; int sl, rl; logic bm; int a0, r0;
    a0 = n_abt; r0 = n_rxv;
    tx_data = 16'h7777; tx_valid = 1'b1;
    spi_xfer(16'h0F0F, 9, mw, sl, rl, bm);
    tx_valid = 1'b0;
    checks++; if (n_abt - a0 !== 1) $display("FAIL abt_count: got %0d want 1", n_abt - a0); else passes++;
    checks++; if (n_rxv - r0 !== 0) $display("FAIL abt_rx_valid_count: got %0d want 0", n_rxv - r0); else passes++;
    checks++; if (rx_data !== 16'hFFFF) $display("FAIL abt_rx_retained: got %h want ffff", rx_data); else passes++;
    checks++; if (MISO !== 1'b0) $display("FAIL abt_miso: got %b want 0", MISO); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abt_busy: got %b want 0", busy); else passes++;
    tx_data = 16'hBEEF; tx_valid = 1'b1;
    spi_xfer(16'h1234, 16, mw, sl, rl, bm);
    tx_valid = 1'b0;
    checks++; if (rx_data !== 16'h1234) $display("FAIL abt_next_rx_data: got %h want 1234", rx_data); else passes++;
    checks++; if (mw !== 16'hBEEF) $display("FAIL abt_next_miso: got %h want beef", mw); else passes++;
  endtask

  task automatic test_extra_clocks();
    logic [15:0] mw; int sl, rl; logic bm; int r0;
    r0 = n_rxv;
    tx_data = 16'h0F0F; tx_valid = 1'b1;
    spi_xfer(16'h8001, 20, mw, sl, rl, bm);
    tx_valid = 1'b0;
    checks++; if (rx_data !== 16'h8001) $display("FAIL xtra_rx_data: got %h want 8001", rx_data); else passes++;
    checks++; if (n_rxv - r0 !== 1) $display("FAIL xtra_rx_valid_count: got %0d want 1", n_rxv - r0); else passes++;
    checks++; if (mw !== 16'h0F0F) $display("FAIL xtra_miso_stream: got %h want 0f0f", mw); else passes++;
    checks++; if (rl !== 5) $display("FAIL xtra_rx_valid_latency: got %0d want 5", rl); else passes++;
  endtask

  task automatic test_reset_mid_frame();
    int t0, r0, a0;
    tx_data = 16'hFFFF; tx_valid = 1'b1;
    @(negedge SLK);
    CS = 1'b1;
    repeat (10) @(negedge SLK);
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      repeat (6) @(negedge SLK);
      SCK = 1'b1; repeat (6) @(negedge SLK);
      SCK = 1'b0;
    end
    repeat (6) @(negedge SLK);
    checks++; if (busy !== 1'b1) $display("FAIL rmf_busy_before: got %b want 1", busy); else passes++;
    checks++; if (MISO !== 1'b1) $display("FAIL rmf_miso_before: got %b want 1", MISO); else passes++;
    rst = 1'b1; CS = 1'b0; SCK = 1'b0; MOSI = 1'b0;
    t0 = n_txr; r0 = n_rxv; a0 = n_abt;
    repeat (3) @(negedge SLK);
    checks++; if (MISO !== 1'b0) $display("FAIL rmf_miso: got %b want 0", MISO); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rmf_busy: got %b want 0", busy); else passes++;
    checks++; if (rx_data !== 16'h0000) $display("FAIL rmf_rx_data: got %h want 0000", rx_data); else passes++;
    rst = 1'b0; tx_valid = 1'b0;
    repeat (12) @(negedge SLK);
    checks++; if (n_txr - t0 !== 0) $display("FAIL rmf_tx_ready_count: got %0d want 0", n_txr - t0); else passes++;
    checks++; if (n_rxv - r0 !== 0) $display("FAIL rmf_rx_valid_count: got %0d want 0", n_rxv - r0); else passes++;
    checks++; if (n_abt - a0 !== 0) $display("FAIL rmf_abort_count: got %0d want 0", n_abt - a0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rmf_busy_after: got %b want 0", busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_abort();
    test_extra_clocks();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
